// File: rtl/fp_to_int.sv
// Iterative converter from the 13-bit float (sign, 4-bit exp, 8-bit frac) to a 16-bit
// signed integer, truncating toward zero; one left shift per clock, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for an input, in_ready high
// SHIFT | scaling the fraction by 2^exp, one bit per cycle
// DONE  | result held, out_valid high until accepted
module fp_to_int (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [3:0]  exp_in,
    input  logic [7:0]  frac_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] int_out,
    output logic        inexact
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [22:0] work;
    logic [3:0]  cnt;
    logic        sign_q;
    logic [15:0] mag_ext;
    logic [15:0] result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The integer part sits above the 8 fraction bits; max magnitude 32640 needs no saturation.
    assign mag_ext = {1'b0, work[22:8]};
    assign result  = sign_q ? (~mag_ext + 16'd1) : mag_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work    <= '0;
            cnt     <= '0;
            sign_q  <= 1'b0;
            int_out <= '0;
            inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work   <= {15'd0, frac_in};
                        cnt    <= exp_in;
                        sign_q <= sign_in;
                    end
                end
                SHIFT: begin
                    if (cnt != 4'd0) begin
                        work <= work << 1;
                        cnt  <= cnt - 4'd1;
                    end else begin
                        int_out <= result;
                        inexact <= |work[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int.sv
// Self-checking bench for fp_to_int: directed boundary cases, random conversions against an
// arithmetic reference model, backpressure and asynchronous reset mid-conversion.
module tb_fp_to_int;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [3:0]  exp_in;
    logic [7:0]  frac_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] int_out;
    logic        inexact;

    int pass_cnt = 0;
    int total_cnt = 0;

    fp_to_int dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .frac_in   (frac_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .int_out   (int_out),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    // value = frac/256 * 2^exp, truncated toward zero
    function automatic void ref_model(input bit s, input int e, input int f,
                                      output logic [15:0] r, output logic x);
        int prod;
        int mag;
        prod = f * (1 << e);
        mag  = prod / 256;
        x    = (prod % 256) != 0;
        r    = 16'(s ? -mag : mag);
    endfunction

    // Drives one conversion with out_ready raised once out_valid is seen; reports what it observed.
    task automatic do_convert(input bit s, input logic [3:0] e, input logic [7:0] f,
                              output logic [15:0] r, output logic x, output int lat,
                              output bit busy_ready, output bit ready_after, output bit to);
        int n;
        to = 0; busy_ready = 0; ready_after = 0; lat = 0; r = '0; x = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (in_ready !== 1'b1) begin
            to = 1;
            return;
        end
        sign_in = s; exp_in = e; frac_in = f; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sign_in = 1'($urandom); exp_in = 4'($urandom); frac_in = 8'($urandom);
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) busy_ready = 1;
            @(posedge clk); #1; lat++;
        end
        if (out_valid !== 1'b1) begin
            to = 1;
            return;
        end
        if (in_ready !== 1'b0) busy_ready = 1;
        r = int_out; x = inexact;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        ready_after = (in_ready === 1'b1) && (out_valid === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sign_in = 1'b0; exp_in = '0; frac_in = '0;
        #3;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (int_out !== 16'h0000) $display("FAIL reset_int_out got %h want 0000", int_out); else pass_cnt++;
        total_cnt++; if (inexact !== 1'b0) $display("FAIL reset_inexact got %b want 0", inexact); else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          s;
        logic [3:0]  e;
        logic [7:0]  f;
        logic [15:0] want_r;
        logic        want_x;
        int          want_lat;
    } vec_t;

    task automatic test_boundaries();
        vec_t vecs[9];
        logic [15:0] r;
        logic x;
        int lat;
        bit busy, rdy, to;
        vecs[0] = '{0, 4'd8,  8'h80, 16'h0080, 1'b0, 9};
        vecs[1] = '{1, 4'd15, 8'hFF, 16'h8080, 1'b0, 16};
        vecs[2] = '{0, 4'd3,  8'hA5, 16'h0005, 1'b1, 4};
        vecs[3] = '{1, 4'd3,  8'hA5, 16'hFFFB, 1'b1, 4};
        vecs[4] = '{1, 4'd0,  8'hFF, 16'h0000, 1'b1, 1};
        vecs[5] = '{0, 4'd7,  8'h00, 16'h0000, 1'b0, 8};
        vecs[6] = '{1, 4'd12, 8'h00, 16'h0000, 1'b0, 13};
        vecs[7] = '{0, 4'd5,  8'h01, 16'h0000, 1'b1, 6};
        vecs[8] = '{1, 4'd9,  8'h01, 16'hFFFE, 1'b0, 10};
        foreach (vecs[i]) begin
            do_convert(vecs[i].s, vecs[i].e, vecs[i].f, r, x, lat, busy, rdy, to);
            total_cnt++;
            if (to) begin
                $display("FAIL bnd%0d_timeout handshake did not complete", i);
                continue;
            end else pass_cnt++;
            total_cnt++; if (r !== vecs[i].want_r) $display("FAIL bnd%0d_int_out got %h want %h", i, r, vecs[i].want_r); else pass_cnt++;
            total_cnt++; if (x !== vecs[i].want_x) $display("FAIL bnd%0d_inexact got %b want %b", i, x, vecs[i].want_x); else pass_cnt++;
            total_cnt++; if (lat !== vecs[i].want_lat) $display("FAIL bnd%0d_latency got %0d want %0d", i, lat, vecs[i].want_lat); else pass_cnt++;
            total_cnt++; if (busy) $display("FAIL bnd%0d_in_ready_busy got 1 want 0 while busy", i); else pass_cnt++;
            total_cnt++; if (!rdy) $display("FAIL bnd%0d_ready_after got 0 want 1 after handshake", i); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [15:0] r, want_r;
        logic x, want_x;
        int lat;
        bit busy, rdy, to;
        bit s;
        logic [3:0] e;
        logic [7:0] f;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom); e = 4'($urandom); f = 8'($urandom);
            ref_model(s, int'(e), int'(f), want_r, want_x);
            do_convert(s, e, f, r, x, lat, busy, rdy, to);
            total_cnt++;
            if (to) begin
                $display("FAIL rnd%0d_timeout handshake did not complete", i);
                continue;
            end else pass_cnt++;
            total_cnt++; if (r !== want_r) $display("FAIL rnd%0d_int_out s=%b e=%0d f=%h got %h want %h", i, s, e, f, r, want_r); else pass_cnt++;
            total_cnt++; if (x !== want_x) $display("FAIL rnd%0d_inexact got %b want %b", i, x, want_x); else pass_cnt++;
            total_cnt++; if (lat !== int'(e) + 1) $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, int'(e) + 1); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        sign_in = 1'b0; exp_in = 4'd4; frac_in = 8'hC0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        total_cnt++; if (n !== 5) $display("FAIL bp_latency got %0d want 5", n); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom); sign_in = 1'($urandom); exp_in = 4'($urandom); frac_in = 8'($urandom);
            @(posedge clk); #1;
            total_cnt++;
            if (int_out !== 16'd12 || in_ready !== 1'b0 || out_valid !== 1'b1)
                $display("FAIL bp_hold%0d got int_out=%h in_ready=%b out_valid=%b want 000c 0 1", i, int_out, in_ready, out_valid);
            else pass_cnt++;
        end
        sign_in = 1'b0; exp_in = 4'd2; frac_in = 8'h80; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_handshake got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_next_accept got in_ready=%b want 0", in_ready); else pass_cnt++;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        total_cnt++; if (n !== 3) $display("FAIL bp_next_latency got %0d want 3", n); else pass_cnt++;
        total_cnt++; if (int_out !== 16'd2) $display("FAIL bp_next_int_out got %h want 0002", int_out); else pass_cnt++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        logic x;
        int lat;
        bit busy, rdy, to;
        sign_in = 1'b0; exp_in = 4'd10; frac_in = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rm_busy got in_ready=%b want 0", in_ready); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rm_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rm_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (int_out !== 16'h0000) $display("FAIL rm_int_out got %h want 0000", int_out); else pass_cnt++;
        @(negedge clk); reset = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        do_convert(1'b0, 4'd1, 8'h80, r, x, lat, busy, rdy, to);
        total_cnt++;
        if (to) $display("FAIL rm_next_timeout handshake did not complete");
        else pass_cnt++;
        total_cnt++; if (r !== 16'd1) $display("FAIL rm_next_int_out got %h want 0001", r); else pass_cnt++;
        total_cnt++; if (x !== 1'b0) $display("FAIL rm_next_inexact got %b want 0", x); else pass_cnt++;
        total_cnt++; if (lat !== 2) $display("FAIL rm_next_latency got %0d want 2", lat); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_boundaries();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fp_to_int.md
# fp_to_int

Sequential converter from the team's 13-bit floating-point format (1-bit sign, 4-bit unsigned exponent, 8-bit fraction, value = (-1)^sign × 0.frac × 2^exp) to a 16-bit two's-complement integer. It is the consuming end of the float datapath: results produced by the floating-point adder are turned back into plain integers here. Conversion is iterative, one left shift per clock, with a valid/ready handshake on both sides.

## Interface
- No parameters; all widths are fixed by the float format.
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; forces IDLE
- in_valid  input  1  sign_in/exp_in/frac_in hold a value to convert
- in_ready  output  1  converter is in IDLE and can accept an input
- sign_in  input  1  float sign, 1 = negative
- exp_in  input  4  float exponent, unsigned 0..15
- frac_in  input  8  float fraction; the MSB is not required to be 1
- out_valid  output  1  int_out and inexact are valid
- out_ready  input  1  downstream accepts the result
- int_out  output  16  signed result, truncated toward zero
- inexact  output  1  nonzero fraction bits were discarded

## Operation
- States:
  - IDLE: in_ready = 1.
  - SHIFT: busy.
  - DONE: out_valid = 1.
- IDLE: when in_valid & in_ready at an edge:
  - W[22:0] <= {15'b0, frac_in}
  - cnt[3:0] <= exp_in
  - sign register <= sign_in
  - state <= SHIFT
- SHIFT:
  - If cnt != 0: W <= W << 1, cnt <= cnt - 1.
  - If cnt == 0: register the result and go to DONE.
    - mag[14:0] = W[22:8]
    - int_out <= sign ? -{1'b0, mag} : {1'b0, mag}
    - inexact <= |W[7:0]
- DONE: int_out and inexact stay stable while out_ready = 0. When out_valid & out_ready at an edge, go to IDLE. out_valid then drops in the next cycle.
- Width rules:
  - The largest magnitude is 255 × 2^7 = 32640, which fits 15 bits. No saturation logic is needed.
  - A negative result whose magnitude truncates to 0 gives int_out = 0 (no negative zero).
- in_valid is ignored outside IDLE. Input fields are sampled only on the accepting edge and may change afterwards.
- Unnormalized fractions (frac_in[7] = 0) use the same formula. frac_in = 0 gives 0 with inexact = 0.
- Reset, including during SHIFT or DONE: the conversion is aborted, with no partial result and no out_valid pulse.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1
  - out_valid = 0
  - int_out = 16'h0000
  - inexact = 0
  - W = 0, cnt = 0
- in_ready and out_valid are decoded from the state register only. Neither depends combinationally on in_valid or out_ready.
- Latency: for an input accepted at edge k, out_valid is high from the cycle after edge k+exp_in+1.
  - exp_in = 0 gives 1 cycle of SHIFT.
  - exp_in = 15 gives 16 cycles of SHIFT.
- After the result handshake at edge m, in_ready is high from the cycle after edge m. The earliest next accept is edge m+1.
- Throughput: one conversion per exp_in + 3 cycles at best, with no overlap between conversions.
- int_out and inexact change only on the SHIFT→DONE edge and on reset. They keep their last values in IDLE.

## Test plan
- Basic conversion, exact:
  - Stimulus: sign=0, exp=8, frac=8'h80, out_ready held at 1.
  - Response: int_out = 16'h0080 (128), inexact = 0.
  - out_valid rises in the 9th cycle after the accept edge.
  - in_ready is low from the cycle after the accept until the cycle after the result handshake.
- Largest negative value:
  - Stimulus: sign=1, exp=15, frac=8'hFF.
  - Response: int_out = 16'h8080 (-32640), inexact = 0, exactly 16 SHIFT cycles.
- Truncation:
  - Stimulus: sign=0, exp=3, frac=8'hA5 (1320/256).
  - Response: int_out = 5, inexact = 1.
  - Stimulus: sign=1, same exp and frac.
  - Response: int_out = 16'hFFFB (-5), inexact = 1.
- Underflow:
  - Stimulus: sign=1, exp=0, frac=8'hFF.
  - Response: int_out = 0, inexact = 1, out_valid one cycle after SHIFT is entered.
  - Stimulus: frac=0, any exp.
  - Response: int_out = 0, inexact = 0.
- Backpressure:
  - Stimulus: convert exp=4, frac=8'hC0 (result 12). Hold out_ready = 0 for 5 cycles after out_valid rises, pulsing in_valid with other data during that time.
  - Response: int_out = 12 stays stable and in_ready = 0 throughout.
  - No new conversion is accepted until the cycle after out_ready = 1 completes the handshake.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously in the 3rd SHIFT cycle of an exp=10 conversion.
  - Response: immediately out_valid = 0, in_ready = 1, int_out = 0.
  - The next conversion, exp=1, frac=8'h80 (result 1), completes correctly with no leftover state.
